// File: rtl/rx_dest_drain.sv
// ============================================================================
// Module   : rx_dest_drain
// Purpose  : Drains destination FIFOs D0/D1 via their pop handshake, tags each
//            word with its source id and buffers it in an internal output FIFO
//            for a downstream consumer. INIT/IDLE/ACTIVE control FSM,
//            round-robin source arbiter, hysteresis almost-full flag.
// Ports    : clk, RESET (sync, active-high), init (re-enter INIT, latch thr.)
//            D0_empty/D1_empty/D0_data/D1_data/POP_D0/POP_D1 : source side
//            out_af_low/out_af_high/out_ae_thr                : flag thresholds
//            POP_OUT/DATA_OUT/valid_out                       : consumer side
//            out_empty/almost_full/almost_empty               : occupancy flags
//            idle_out/active_out/error_out                    : status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_dest_drain #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              init,
  input  logic              D0_empty,
  input  logic              D1_empty,
  input  logic [DATA_W-1:0] D0_data,
  input  logic [DATA_W-1:0] D1_data,
  output logic              POP_D0,
  output logic              POP_D1,
  input  logic [4:0]        out_af_low,
  input  logic [4:0]        out_af_high,
  input  logic [4:0]        out_ae_thr,
  input  logic              POP_OUT,
  output logic [DATA_W:0]   DATA_OUT,
  output logic              valid_out,
  output logic              out_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out
);

  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = PTR_W + 2;
  localparam int THR_W = 5;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t            state_q;
  logic              idle_q, active_q;
  logic [THR_W-1:0]  af_lo_q, af_hi_q, ae_thr_q;
  logic [THR_W-1:0]  af_lo_d, af_hi_d, ae_thr_d;
  logic              rr_q;          // 1 = D1 preferred on the next contested grant
  logic              cap_q;         // a pop was issued last cycle; its data is on Dx_data now
  logic              cap_src_q;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W:0]   data_out_q;
  logic              valid_q, err_q, empty_q, ae_q, af_q, af_d;

  logic              w_any_src, w_room, w_pop_en, w_gnt0, w_gnt1, w_wr, w_rd;
  logic [SUM_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_cap_data;

  // ---------------------------------------------------------------- arbiter
  // Pops are combinational from registered state so that the word lands in
  // the buffer exactly one cycle later; the only word not yet counted in
  // count_q at decision time is the one captured this cycle (cap_q).
  assign w_any_src = !D0_empty || !D1_empty;
  assign w_occ     = SUM_W'(count_q) + SUM_W'(cap_q);
  assign w_room    = w_occ < SUM_W'(DEPTH);
  assign w_pop_en  = !RESET && (state_q == ST_ACTIVE) && !af_q && w_room;
  assign w_gnt0    = w_pop_en && !D0_empty && (D1_empty || !rr_q);
  assign w_gnt1    = w_pop_en && !D1_empty && (D0_empty ||  rr_q);
  assign POP_D0    = w_gnt0;
  assign POP_D1    = w_gnt1;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= ST_RST;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q  <= ST_INIT;
          idle_q   <= 1'b0;
          active_q <= 1'b0;
        end
        ST_INIT: begin
          if (!init) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
          end else if (w_any_src) begin
            state_q  <= ST_ACTIVE;
            idle_q   <= 1'b0;
            active_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (init) begin
            state_q  <= ST_INIT;
            active_q <= 1'b0;
          end else if (!w_any_src && !cap_q) begin
            state_q  <= ST_IDLE;
            idle_q   <= 1'b1;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RST;
          idle_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------ next-state values
  // Thresholds seen by the flag logic are the ones valid after this edge, so
  // the flags never lag a threshold update.
  assign af_lo_d  = (state_q == ST_INIT) ? out_af_low  : af_lo_q;
  assign af_hi_d  = (state_q == ST_INIT) ? out_af_high : af_hi_q;
  assign ae_thr_d = (state_q == ST_INIT) ? out_ae_thr  : ae_thr_q;

  assign w_wr       = cap_q;
  assign w_rd       = POP_OUT && (count_q != '0);   // no bypass of the word being captured
  assign w_cap_data = cap_src_q ? D1_data : D0_data;

  always_comb begin
    count_d = count_q;
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear; between the thresholds the flag holds.
  always_comb begin
    af_d = af_q;
    if (THR_W'(count_d) >= af_hi_d)
      af_d = 1'b1;
    else if (THR_W'(count_d) <= af_lo_d)
      af_d = 1'b0;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!RESET && w_wr)
      mem_q[wptr_q] <= {cap_src_q, w_cap_data};
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      af_lo_q    <= '0;
      af_hi_q    <= '0;
      ae_thr_q   <= '0;
      rr_q       <= 1'b0;
      cap_q      <= 1'b0;
      cap_src_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
      af_q       <= 1'b0;
    end else begin
      af_lo_q   <= af_lo_d;
      af_hi_q   <= af_hi_d;
      ae_thr_q  <= ae_thr_d;
      cap_q     <= w_gnt0 || w_gnt1;
      cap_src_q <= w_gnt1;
      if (w_gnt0 || w_gnt1)
        rr_q <= w_gnt0;
      if (w_wr)
        wptr_q <= wptr_q + PTR_W'(1);
      if (w_rd) begin
        data_out_q <= mem_q[rptr_q];
        rptr_q     <= rptr_q + PTR_W'(1);
      end
      valid_q <= w_rd;
      if (POP_OUT && (count_q == '0))
        err_q <= 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      ae_q    <= (THR_W'(count_d) <= ae_thr_d);
      af_q    <= af_d;
    end
  end

  assign DATA_OUT     = data_out_q;
  assign valid_out    = valid_q;
  assign out_empty    = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign idle_out     = idle_q;
  assign active_out   = active_q;
  assign error_out    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_dest_drain.sv
// ============================================================================
// Module   : tb_rx_dest_drain
// Purpose  : Directed self-checking bench for rx_dest_drain. Behavioural
//            models of the D0/D1 source FIFOs feed the DUT; every expected
//            value is written out by hand below.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_dest_drain;

  logic       clk = 1'b0;
  logic       RESET, init, D0_empty, D1_empty, POP_D0, POP_D1, POP_OUT;
  logic [5:0] D0_data, D1_data;
  logic [4:0] out_af_low, out_af_high, out_ae_thr;
  logic [6:0] DATA_OUT;
  logic       valid_out, out_empty, almost_full, almost_empty;
  logic       idle_out, active_out, error_out;

  int         n_checks = 0;
  int         n_errors = 0;
  int         pops0 = 0;
  int         pops1 = 0;
  logic       both_seen = 1'b0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         order[$];

  always #5 clk = ~clk;

  rx_dest_drain #(.DATA_W(6), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .RESET(RESET), .init(init),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_data(D0_data), .D1_data(D1_data),
    .POP_D0(POP_D0), .POP_D1(POP_D1),
    .out_af_low(out_af_low), .out_af_high(out_af_high), .out_ae_thr(out_ae_thr),
    .POP_OUT(POP_OUT), .DATA_OUT(DATA_OUT), .valid_out(valid_out),
    .out_empty(out_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the pop requests settled before the edge, then let the
  // source-FIFO models respond (data valid the cycle after a pop).
  task automatic step();
    logic p0, p1;
    #1;
    p0 = POP_D0;
    p1 = POP_D1;
    if (p0 && p1) both_seen = 1'b1;
    if (p0) begin pops0++; order.push_back(0); end
    if (p1) begin pops1++; order.push_back(1); end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) D0_data = q0.pop_front();
    if (p1 && q1.size() > 0) D1_data = q1.pop_front();
    D0_empty = (q0.size() == 0);
    D1_empty = (q1.size() == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push0(input logic [5:0] d);
    q0.push_back(d);
    D0_empty = 1'b0;
  endtask

  task automatic push1(input logic [5:0] d);
    q1.push_back(d);
    D1_empty = 1'b0;
  endtask

  task automatic do_init(input logic [4:0] lo, input logic [4:0] hi, input logic [4:0] ae);
    out_af_low  = lo;
    out_af_high = hi;
    out_ae_thr  = ae;
    init = 1'b1;
    step();
    init = 1'b0;
    step();
  endtask

  task automatic do_read();
    POP_OUT = 1'b1;
    step();
    POP_OUT = 1'b0;
  endtask

  initial begin
    int snap;
    int got;
    RESET = 1'b1; init = 1'b0; POP_OUT = 1'b0;
    D0_empty = 1'b1; D1_empty = 1'b1; D0_data = '0; D1_data = '0;
    out_af_low = '0; out_af_high = '0; out_ae_thr = '0;

    // ---------------- T1: reset values, then INIT -> IDLE
    steps(2);
    chk("rst_valid",   32'(valid_out),    32'd0);
    chk("rst_error",   32'(error_out),    32'd0);
    chk("rst_data",    32'(DATA_OUT),     32'd0);
    chk("rst_empty",   32'(out_empty),    32'd1);
    chk("rst_ae",      32'(almost_empty), 32'd1);
    chk("rst_af",      32'(almost_full),  32'd0);
    chk("rst_idle",    32'(idle_out),     32'd0);
    chk("rst_active",  32'(active_out),   32'd0);
    chk("rst_pops",    32'(pops0 + pops1), 32'd0);
    RESET = 1'b0;
    do_init(5'd1, 5'd3, 5'd1);
    chk("t1_idle",     32'(idle_out),     32'd1);
    chk("t1_active",   32'(active_out),   32'd0);
    chk("t1_af",       32'(almost_full),  32'd0);

    // ---------------- T2: single word from D0
    push0(6'b001010);
    steps(4);  // ->ACTIVE, pop, capture, ->IDLE
    chk("t2_pops",     32'(pops0),        32'd1);
    chk("t2_empty",    32'(out_empty),    32'd0);
    chk("t2_ae",       32'(almost_empty), 32'd1);
    chk("t2_idle",     32'(idle_out),     32'd1);
    do_read();
    chk("t2_valid",    32'(valid_out),    32'd1);
    chk("t2_data",     32'(DATA_OUT),     32'h0A);
    chk("t2_empty2",   32'(out_empty),    32'd1);
    step();
    chk("t2_valid_lo", 32'(valid_out),    32'd0);
    chk("t2_data_hld", 32'(DATA_OUT),     32'h0A);

    // ---------------- T3: round robin, fresh reset so D0 goes first
    RESET = 1'b1;
    steps(2);
    RESET = 1'b0;
    do_init(5'd2, 5'd8, 5'd1);
    order.delete();
    for (int i = 0; i < 4; i++) begin
      push0(6'h10 + 6'(i));
      push1(6'h20 + 6'(i));
    end
    steps(12);
    chk("t3_npops",    32'(order.size()), 32'd8);
    for (int i = 0; i < 8 && i < order.size(); i++)
      chk("t3_order", 32'(order[i]), 32'(i % 2));
    chk("t3_af_full",  32'(almost_full),  32'd1);
    chk("t3_idle",     32'(idle_out),     32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [6:0] e;
      e = (i % 2 == 0) ? {1'b0, 6'h10 + 6'(i / 2)} : {1'b1, 6'h20 + 6'(i / 2)};
      do_read();
      chk("t3_valid", 32'(valid_out), 32'd1);
      chk("t3_data",  32'(DATA_OUT),  32'(e));
    end
    chk("t3_empty",    32'(out_empty),    32'd1);

    // ---------------- T4: back-pressure with af_high=3, af_low=1
    do_init(5'd1, 5'd3, 5'd1);
    snap = pops0;
    for (int i = 0; i < 6; i++) push0(6'h30 + 6'(i));
    steps(10);
    // The pop granted while count was 2 is still in flight when the flag
    // rises at count 3, so four words land before pops stop.
    chk("t4_pops_stop", 32'(pops0 - snap), 32'd4);
    chk("t4_af_set",    32'(almost_full),  32'd1);
    chk("t4_active",    32'(active_out),   32'd1);
    do_read();
    chk("t4_d0", 32'(DATA_OUT), 32'h30);
    do_read();
    chk("t4_d1", 32'(DATA_OUT), 32'h31);
    chk("t4_af_hold",   32'(almost_full),  32'd1);   // count 2, between thresholds
    chk("t4_no_pop",    32'(pops0 - snap), 32'd4);
    do_read();
    chk("t4_d2", 32'(DATA_OUT), 32'h32);
    chk("t4_af_clr",    32'(almost_full),  32'd0);   // count 1 <= af_low
    steps(6);
    chk("t4_resume",    32'(pops0 - snap), 32'd6);
    for (int i = 3; i < 6; i++) begin
      do_read();
      chk("t4_tail", 32'(DATA_OUT), 32'(6'h30 + 6'(i)));
    end
    chk("t4_empty",     32'(out_empty),    32'd1);

    // ---------------- T5: 20 words across pointer wrap, periodic consumer
    do_init(5'd4, 5'd8, 5'd1);
    for (int i = 0; i < 20; i++) push0(6'(i + 5));
    got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      POP_OUT = !out_empty && (cyc % 3 == 0);
      step();
      if (valid_out) begin
        chk("t5_data", 32'(DATA_OUT), 32'(got + 5));
        got++;
      end
    end
    POP_OUT = 1'b0;
    chk("t5_count",     32'(got),          32'd20);
    chk("t5_no_err",    32'(error_out),    32'd0);
    chk("t5_empty",     32'(out_empty),    32'd1);

    // ---------------- T6: underflow is sticky; reset mid-operation
    do_read();
    chk("t6_err",       32'(error_out),    32'd1);
    chk("t6_valid",     32'(valid_out),    32'd0);
    steps(3);
    chk("t6_err_stky",  32'(error_out),    32'd1);
    snap = pops0;
    for (int i = 0; i < 5; i++) push0(6'h3A + 6'(i));
    steps(6);  // count reaches 4 with the fifth word in flight
    chk("t6_active",    32'(active_out),   32'd1);
    chk("t6_pops",      32'(pops0 - snap), 32'd5);
    chk("t6_ae_lo",     32'(almost_empty), 32'd0);
    RESET = 1'b1;
    step();
    chk("t6_r_empty",   32'(out_empty),    32'd1);
    chk("t6_r_err",     32'(error_out),    32'd0);
    chk("t6_r_active",  32'(active_out),   32'd0);
    chk("t6_r_ae",      32'(almost_empty), 32'd1);
    chk("t6_r_data",    32'(DATA_OUT),     32'd0);
    RESET = 1'b0;
    do_init(5'd1, 5'd3, 5'd1);
    steps(3);
    chk("t6_drop",      32'(out_empty),    32'd1);
    chk("t6_idle",      32'(idle_out),     32'd1);
    chk("never_both",   32'(both_seen),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
